axis_fir_coeff_loader: RTL and testbench
========================================

// Module: axis_fir_coeff_loader
//
// PURPOSE
// Upstream configuration stage for axis_fir_filter: accepts a coefficient frame on an AXI-Stream
// slave (one coefficient per beat, TLAST on final beat) and converts it to the filter's
// COEFF_ADDR/COEFF_DATA/COEFF_VALID write port. Checks frame length, drops malformed frames.
// Sits between the host/DMA config stream and the filter's coefficient inputs.
//
// PARAMETERS
// N_BYTES          4   coefficient width in bytes; DATA_WIDTH = N_BYTES*8 (matches filter)
// COEFF_ADDR_WIDTH 6   width of COEFF_ADDR (matches filter)
// N_WORDS          32  coefficients per frame; 2 <= N_WORDS <= 2**COEFF_ADDR_WIDTH
//
// PORTS
// CLK            in   1                 clock
// RESET          in   1                 synchronous, active-high reset
// S_AXIS_TDATA   in   N_BYTES*8         coefficient word, two's complement
// S_AXIS_TVALID  in   1                 beat valid
// S_AXIS_TREADY  out  1                 beat accepted when TVALID & TREADY
// S_AXIS_TLAST   in   1                 last beat of coefficient frame
// COEFF_ADDR     out  COEFF_ADDR_WIDTH  write address to filter
// COEFF_DATA     out  N_BYTES*8         write data to filter
// COEFF_VALID    out  1                 write strobe, one cycle per coefficient
// LOAD_DONE      out  1                 1-cycle pulse: full frame written
// LOAD_ERROR     out  1                 1-cycle pulse: frame rejected (length mismatch)
// BUSY           out  1                 high whenever FSM not in IDLE_ST
//
// BEHAVIOUR
// - Reset: all outputs 0, beat index idx=0, FSM IDLE_ST. S_AXIS_TREADY is registered; it rises
//   the first cycle after RESET deasserts. Reset mid-frame abandons frame, no pulses issued.
// - idx counts accepted beats 0..N_WORDS-1 within a frame; cleared on any return to IDLE_ST.
// - FSM: IDLE_ST -(accepted beat, no TLAST)-> LOAD_ST; LOAD_ST -(TLAST, idx==N_WORDS-1)-> IDLE_ST
//   (or COMMIT_ST with macro); -(TLAST, idx<N_WORDS-1)-> IDLE_ST + error;
//   -(idx==N_WORDS-1, no TLAST)-> DRAIN_ST + error; DRAIN_ST -(TLAST accepted)-> IDLE_ST.
// - Accepted beat with TLAST while in IDLE_ST (1-beat frame) -> error, stays IDLE_ST.
// - DRAIN_ST: TREADY=1, beats discarded, no COEFF_VALID, no further pulses.
// - LOAD_DONE/LOAD_ERROR asserted exactly one cycle, registered, never both in same cycle.
// - Error pulse: cycle after the offending beat is accepted (TLAST early, or beat N_WORDS-1 w/o TLAST).
// - COEFF_DATA passed bit-exact, no arithmetic; COEFF_ADDR = idx zero-extended.
// - Back-to-back frames supported: new frame may start the cycle after TLAST beat (no-macro mode).
//
// CONFIGURATION
// Macro AXIS_FIR_COEFF_LOADER_SHADOW_EN:
// - Undefined (write-through): each accepted beat in IDLE_ST/LOAD_ST produces COEFF_VALID=1,
//   COEFF_ADDR=idx, COEFF_DATA=TDATA on the next cycle (latency 1). TREADY stays 1 outside reset.
//   LOAD_DONE pulses the cycle after the good TLAST beat (same cycle as last write).
//   Short frames leave already-written coefficients in the filter (partial update).
// - Defined (shadow): beats go to an internal N_WORDS x DATA_WIDTH shadow array, no writes while
//   loading. Good frame -> COMMIT_ST: TREADY=0, N_WORDS consecutive COEFF_VALID cycles, addr 0..N_WORDS-1
//   ascending starting the cycle after TLAST beat; LOAD_DONE pulses the cycle after the last write;
//   then IDLE_ST, TREADY=1. Bad frame: zero writes, filter coefficients untouched. Reset in COMMIT_ST
//   stops writes immediately.
//
// TESTING
// 1 Reset, then 32-beat frame 0x0000..0x001F, TLAST on beat 31 -> 32 writes addr==data, 1 LOAD_DONE.
// 2 Frame of 5 beats, TLAST on beat 4 -> LOAD_ERROR once; shadow: 0 writes; write-through: 5 writes.
// 3 40-beat frame, TLAST on 39 -> LOAD_ERROR after beat 31, beats 32..39 dropped, BUSY low after 39.
// 4 Two good frames back-to-back, random TVALID gaps -> 64 writes, 2 LOAD_DONE, data/addr in order.
// 5 RESET asserted at beat 10 of a frame, then good frame -> no pulses from first, second loads cleanly.
// 6 Shadow: TVALID held during COMMIT_ST -> TREADY=0 for 32 cycles, next frame accepted afterwards.

Source files
------------

// File: rtl/axis_fir_coeff_loader.sv
// ============================================================================
// Module      : axis_fir_coeff_loader
// Description : Coefficient frame loader for axis_fir_filter. Accepts one
//               coefficient per AXI-Stream beat (TLAST on the final beat),
//               checks the frame length and drives the filter's
//               COEFF_ADDR/COEFF_DATA/COEFF_VALID write port.
//               Optional macro AXIS_FIR_COEFF_LOADER_SHADOW_EN: buffer the
//               frame in a shadow array and commit it only when complete.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_fir_coeff_loader #(
    parameter int N_BYTES          = 4,
    parameter int COEFF_ADDR_WIDTH = 6,
    parameter int N_WORDS          = 32
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [N_BYTES*8-1:0]        S_AXIS_TDATA,
    input  logic                        S_AXIS_TVALID,
    output logic                        S_AXIS_TREADY,
    input  logic                        S_AXIS_TLAST,
    output logic [COEFF_ADDR_WIDTH-1:0] COEFF_ADDR,
    output logic [N_BYTES*8-1:0]        COEFF_DATA,
    output logic                        COEFF_VALID,
    output logic                        LOAD_DONE,
    output logic                        LOAD_ERROR,
    output logic                        BUSY
);

    localparam int DATA_WIDTH = N_BYTES * 8;
    // One spare bit so the commit counter can reach N_WORDS itself.
    localparam int IDX_W = COEFF_ADDR_WIDTH + 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE_ST   = 2'd0,
        LOAD_ST   = 2'd1,
        DRAIN_ST  = 2'd2,
        COMMIT_ST = 2'd3
    } state_t;

    state_t                        r_state;
    logic [IDX_W-1:0]              r_idx;
    logic                          r_tready;
    logic                          r_coeff_valid;
    logic [COEFF_ADDR_WIDTH-1:0]   r_coeff_addr;
    logic [DATA_WIDTH-1:0]         r_coeff_data;
    logic                          r_load_done;
    logic                          r_load_error;
    logic                          w_accept;

`ifdef AXIS_FIR_COEFF_LOADER_SHADOW_EN
    localparam int SH_AW = $clog2(N_WORDS);
    localparam logic [IDX_W-1:0] C_N_WORDS = IDX_W'(N_WORDS);
    logic [DATA_WIDTH-1:0] r_shadow [0:N_WORDS-1];
`endif

    assign w_accept = S_AXIS_TVALID & r_tready;

    // Frame FSM: beat counting, length checking, write port and pulse generation.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE_ST;
            r_idx         <= '0;
            r_tready      <= 1'b0;
            r_coeff_valid <= 1'b0;
            r_coeff_addr  <= '0;
            r_coeff_data  <= '0;
            r_load_done   <= 1'b0;
            r_load_error  <= 1'b0;
        end else begin
            r_coeff_valid <= 1'b0;
            r_load_done   <= 1'b0;
            r_load_error  <= 1'b0;
            r_tready      <= 1'b1;
            case (r_state)
                // IDLE and LOAD share one rule set: idx is 0 in IDLE, so a
                // TLAST there is always an early (1-beat) frame.
                IDLE_ST, LOAD_ST: begin
                    if (w_accept) begin
`ifdef AXIS_FIR_COEFF_LOADER_SHADOW_EN
                        r_shadow[r_idx[SH_AW-1:0]] <= S_AXIS_TDATA;
`else
                        r_coeff_valid <= 1'b1;
                        r_coeff_addr  <= r_idx[COEFF_ADDR_WIDTH-1:0];
                        r_coeff_data  <= S_AXIS_TDATA;
`endif
                        if (S_AXIS_TLAST) begin
                            r_idx   <= '0;
                            r_state <= IDLE_ST;
                            if (r_idx == C_LAST_IDX) begin
`ifdef AXIS_FIR_COEFF_LOADER_SHADOW_EN
                                // Start the commit burst right away with address 0.
                                r_state       <= COMMIT_ST;
                                r_tready      <= 1'b0;
                                r_coeff_valid <= 1'b1;
                                r_coeff_addr  <= '0;
                                r_coeff_data  <= r_shadow[0];
                                r_idx         <= IDX_W'(1);
`else
                                r_load_done   <= 1'b1;
`endif
                            end else begin
                                r_load_error <= 1'b1;
                            end
                        end else if (r_idx == C_LAST_IDX) begin
                            r_load_error <= 1'b1;
                            r_state      <= DRAIN_ST;
                            r_idx        <= '0;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= LOAD_ST;
                        end
                    end
                end
                DRAIN_ST: begin
                    if (w_accept && S_AXIS_TLAST) begin
                        r_state <= IDLE_ST;
                    end
                end
`ifdef AXIS_FIR_COEFF_LOADER_SHADOW_EN
                COMMIT_ST: begin
                    if (r_idx == C_N_WORDS) begin
                        r_load_done <= 1'b1;
                        r_state     <= IDLE_ST;
                        r_idx       <= '0;
                    end else begin
                        r_tready      <= 1'b0;
                        r_coeff_valid <= 1'b1;
                        r_coeff_addr  <= r_idx[COEFF_ADDR_WIDTH-1:0];
                        r_coeff_data  <= r_shadow[r_idx[SH_AW-1:0]];
                        r_idx         <= r_idx + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE_ST;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign S_AXIS_TREADY = r_tready;
    assign COEFF_VALID   = r_coeff_valid;
    assign COEFF_ADDR    = r_coeff_addr;
    assign COEFF_DATA    = r_coeff_data;
    assign LOAD_DONE     = r_load_done;
    assign LOAD_ERROR    = r_load_error;
    assign BUSY          = (r_state != IDLE_ST);

endmodule

`default_nettype wire

// File: tb/tb_axis_fir_coeff_loader.sv
// ============================================================================
// Module      : tb_axis_fir_coeff_loader
// Description : Directed self-checking bench for axis_fir_coeff_loader
//               (write-through build by default, shadow build with
//               AXIS_FIR_COEFF_LOADER_SHADOW_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_fir_coeff_loader;

`ifdef AXIS_FIR_COEFF_LOADER_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        CLK;
    logic        RESET;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic        S_AXIS_TLAST;
    logic [5:0]  COEFF_ADDR;
    logic [31:0] COEFF_DATA;
    logic        COEFF_VALID;
    logic        LOAD_DONE;
    logic        LOAD_ERROR;
    logic        BUSY;

    axis_fir_coeff_loader #(
        .N_BYTES          (4),
        .COEFF_ADDR_WIDTH (6),
        .N_WORDS          (32)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .COEFF_ADDR    (COEFF_ADDR),
        .COEFF_DATA    (COEFF_DATA),
        .COEFF_VALID   (COEFF_VALID),
        .LOAD_DONE     (LOAD_DONE),
        .LOAD_ERROR    (LOAD_ERROR),
        .BUSY          (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed write port and pulses, sampled on the falling edge.
    int          cyc = 0;
    logic [5:0]  wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          n_done = 0, n_err = 0, n_both = 0, n_tready_low = 0;
    int          done_cyc = -1, err_cyc = -1;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (COEFF_VALID) begin
            wa.push_back(COEFF_ADDR);
            wd.push_back(COEFF_DATA);
            wc.push_back(cyc);
        end
        if (LOAD_DONE)  begin n_done++; done_cyc = cyc; end
        if (LOAD_ERROR) begin n_err++;  err_cyc  = cyc; end
        if (LOAD_DONE && LOAD_ERROR) n_both++;
        if (!RESET && !S_AXIS_TREADY) n_tready_low++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Present one beat (entered and left on a falling edge).
    task automatic send_beat(input logic [31:0] d, input logic last, input int gap);
        int waited;
        S_AXIS_TVALID = 1'b0;
        repeat (gap) @(negedge CLK);
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = last;
        S_AXIS_TVALID = 1'b1;
        waited = 0;
        while (!S_AXIS_TREADY && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        if (!S_AXIS_TREADY) check_eq("tready_timeout", 64'(S_AXIS_TREADY), 64'd1);
        @(negedge CLK);
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int n, input bit gaps);
        for (int i = 0; i < n; i++)
            send_beat(base + 32'(i), (i == n - 1), gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    // Compare n logged writes starting at log index first against addr i, data base+i.
    task automatic check_frame(input string tag, input int first, input int n, input logic [31:0] base);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (first + i >= wa.size()) bad++;
            else if (wa[first+i] !== 6'(i) || wd[first+i] !== base + 32'(i)) bad++;
        end
        check_eq(tag, 64'(bad), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    int w0, d0, e0, t0;

    initial begin
        RESET = 1'b1; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; S_AXIS_TDATA = '0;
        idle(3);
        // Reset state
        check_eq("rst_tready", 64'(S_AXIS_TREADY), 64'd0);
        check_eq("rst_valid",  64'(COEFF_VALID),   64'd0);
        check_eq("rst_busy",   64'(BUSY),          64'd0);
        check_eq("rst_done",   64'(LOAD_DONE),     64'd0);
        check_eq("rst_err",    64'(LOAD_ERROR),    64'd0);
        check_eq("rst_addr",   64'(COEFF_ADDR),    64'd0);
        check_eq("rst_data",   64'(COEFF_DATA),    64'd0);
        RESET = 1'b0;
        idle(1);
        check_eq("tready_rise", 64'(S_AXIS_TREADY), 64'd1);

        // 1: full 32-beat frame, addr == data
        w0 = wa.size(); d0 = n_done; e0 = n_err;
        send_frame(32'h0, 32, 1'b0);
        idle(40);
        check_eq("t1_writes", 64'(wa.size() - w0), 64'd32);
        check_frame("t1_content", w0, 32, 32'h0);
        check_eq("t1_done", 64'(n_done - d0), 64'd1);
        check_eq("t1_err",  64'(n_err - e0),  64'd0);
        check_eq("t1_burst", 64'(wc[w0+31] - wc[w0]), 64'd31);
        check_eq("t1_done_cyc", 64'(done_cyc), 64'(wc[w0+31] + (SHADOW ? 1 : 0)));

        // 2: short 5-beat frame
        w0 = wa.size(); d0 = n_done; e0 = n_err;
        send_frame(32'h100, 5, 1'b0);
        idle(5);
        check_eq("t2_err",    64'(n_err - e0),  64'd1);
        check_eq("t2_done",   64'(n_done - d0), 64'd0);
        check_eq("t2_writes", 64'(wa.size() - w0), SHADOW ? 64'd0 : 64'd5);
        check_frame("t2_content", w0, wa.size() - w0, 32'h100);

        // 3: over-long 40-beat frame
        w0 = wa.size(); d0 = n_done; e0 = n_err;
        for (int i = 0; i < 40; i++) begin
            send_beat(32'h200 + 32'(i), (i == 39), 0);
            if (i == 35) check_eq("t3_busy_drain", 64'(BUSY), 64'd1);
        end
        check_eq("t3_busy_end", 64'(BUSY), 64'd0);
        idle(5);
        check_eq("t3_err",    64'(n_err - e0),  64'd1);
        check_eq("t3_done",   64'(n_done - d0), 64'd0);
        check_eq("t3_writes", 64'(wa.size() - w0), SHADOW ? 64'd0 : 64'd32);
        check_frame("t3_content", w0, wa.size() - w0, 32'h200);
        if (!SHADOW && wa.size() - w0 >= 32)
            check_eq("t3_err_cyc", 64'(err_cyc), 64'(wc[w0+31]));

        // 4: two good frames back to back with random TVALID gaps
        w0 = wa.size(); d0 = n_done; e0 = n_err;
        send_frame(32'h300, 32, 1'b1);
        send_frame(32'h400, 32, 1'b1);
        idle(40);
        check_eq("t4_writes", 64'(wa.size() - w0), 64'd64);
        check_frame("t4_content_a", w0, 32, 32'h300);
        check_frame("t4_content_b", w0 + 32, 32, 32'h400);
        check_eq("t4_done", 64'(n_done - d0), 64'd2);
        check_eq("t4_err",  64'(n_err - e0),  64'd0);

        // 5: reset mid-frame, then a clean frame
        w0 = wa.size(); d0 = n_done; e0 = n_err;
        for (int i = 0; i < 10; i++) send_beat(32'h500 + 32'(i), 1'b0, 0);
        RESET = 1'b1;
        idle(2);
        check_eq("t5_busy_rst", 64'(BUSY), 64'd0);
        RESET = 1'b0;
        idle(1);
        check_eq("t5_err_mid", 64'(n_err - e0), 64'd0);
        send_frame(32'h600, 32, 1'b0);
        idle(40);
        check_eq("t5_done", 64'(n_done - d0), 64'd1);
        check_eq("t5_err",  64'(n_err - e0),  64'd0);
        check_eq("t5_writes", 64'(wa.size() - w0), SHADOW ? 64'd32 : 64'd42);
        check_frame("t5_content", wa.size() - 32, 32, 32'h600);

`ifdef AXIS_FIR_COEFF_LOADER_SHADOW_EN
        // 6: TVALID held across the commit burst
        w0 = wa.size(); d0 = n_done; t0 = n_tready_low;
        send_frame(32'h700, 32, 1'b0);
        send_frame(32'h800, 32, 1'b0);
        idle(40);
        check_eq("t6_tready_low", 64'(n_tready_low - t0), 64'd64);
        check_eq("t6_writes", 64'(wa.size() - w0), 64'd64);
        check_frame("t6_content_a", w0, 32, 32'h700);
        check_frame("t6_content_b", w0 + 32, 32, 32'h800);
        check_eq("t6_done", 64'(n_done - d0), 64'd2);
`endif

        check_eq("never_both", 64'(n_both), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
